// File: rtl/lsc_counter_n.sv
// Parametrised 161-style binary counter: up/down, programmable terminal value,
// synchronous clear/load and a combinational ripple carry for chaining stages.
module lsc_counter_n #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic             SCLR_n,
  input  logic             LOAD_n,
  input  logic [WIDTH-1:0] D,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
  input  logic [WIDTH-1:0] MAX,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             RCO
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             at_top;
  logic             at_zero;
  logic             count_en;

  // ">=" rather than "==" so an out-of-range value (from a load or a MAX
  // reduction) still flags terminal count and wraps on the next up step.
  assign at_top   = (q_q >= MAX);
  assign at_zero  = (q_q == '0);
  assign count_en = ENP & ENT;

  always_comb begin
    q_d = q_q;
    if (!SCLR_n) begin
      q_d = '0;
    end else if (!LOAD_n) begin
      q_d = D;
    end else if (count_en) begin
      if (UP) begin
        q_d = at_top ? '0 : q_q + WIDTH'(1);
      end else begin
        q_d = at_zero ? MAX : q_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  // No register stage on RCO: the next stage must see it before the same edge.
  assign Q   = q_q;
  assign TC  = UP ? at_top : at_zero;
  assign RCO = ENT & TC;

endmodule

// File: tb/tb_lsc_counter_n.sv
// Directed bench for lsc_counter_n: expected values are queued as stimulus is
// applied and compared when the outputs are sampled.
module tb_lsc_counter_n;

  logic       clk;
  logic       clr_n;
  logic       sclr_n;
  logic       load_n;
  logic [7:0] d;
  logic       enp;
  logic       ent;
  logic       up;
  logic [7:0] max;
  logic [7:0] q;
  logic       tc;
  logic       rco;

  logic       c_sclr_n;
  logic       c_enp;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_rco, hi_rco;

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic       tc;
    logic       rco;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  lsc_counter_n #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .CLK(clk), .CLR_n(clr_n), .SCLR_n(sclr_n), .LOAD_n(load_n), .D(d),
    .ENP(enp), .ENT(ent), .UP(up), .MAX(max), .Q(q), .TC(tc), .RCO(rco)
  );

  lsc_counter_n #(.WIDTH(4), .RESET_VAL(4'h0)) u_lo (
    .CLK(clk), .CLR_n(clr_n), .SCLR_n(c_sclr_n), .LOAD_n(1'b1), .D(4'h0),
    .ENP(c_enp), .ENT(1'b1), .UP(1'b1), .MAX(4'hF), .Q(lo_q), .TC(lo_tc), .RCO(lo_rco)
  );

  lsc_counter_n #(.WIDTH(4), .RESET_VAL(4'h0)) u_hi (
    .CLK(clk), .CLR_n(clr_n), .SCLR_n(c_sclr_n), .LOAD_n(1'b1), .D(4'h0),
    .ENP(c_enp), .ENT(lo_rco), .UP(1'b1), .MAX(4'hF), .Q(hi_q), .TC(hi_tc), .RCO(hi_rco)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_exp(input string tag, input logic [7:0] eq,
                                   input logic etc, input logic erco);
    exp_t e;
    e.tag = tag; e.q = eq; e.tc = etc; e.rco = erco;
    sb.push_back(e);
  endfunction

  task automatic check(input logic [7:0] oq, input logic otc, input logic orco);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty got none exp entry");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (oq === e.q) else begin
      errors++;
      $error("FAIL %s Q got %0h exp %0h", e.tag, oq, e.q);
    end
    checks++;
    assert (otc === e.tc) else begin
      errors++;
      $error("FAIL %s TC got %0b exp %0b", e.tag, otc, e.tc);
    end
    checks++;
    assert (orco === e.rco) else begin
      errors++;
      $error("FAIL %s RCO got %0b exp %0b", e.tag, orco, e.rco);
    end
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] dn [4];
    dn = '{8'h01, 8'h00, 8'h0C, 8'h0B};

    clr_n = 1'b0; sclr_n = 1'b1; load_n = 1'b1; d = 8'h00;
    enp = 1'b0; ent = 1'b0; up = 1'b1; max = 8'hFF;
    c_sclr_n = 1'b1; c_enp = 1'b0;

    // reset and asynchronous clear
    push_exp("reset", 8'h00, 1'b0, 1'b0);
    cyc(); check(q, tc, rco);
    clr_n = 1'b1; load_n = 1'b0; d = 8'h37;
    push_exp("load_37", 8'h37, 1'b0, 1'b0);
    cyc(); check(q, tc, rco);
    load_n = 1'b1; enp = 1'b1; ent = 1'b1; up = 1'b1;
    clr_n = 1'b0;
    push_exp("async_clr", 8'h00, 1'b0, 1'b0);
    #2; check(q, tc, rco);
    push_exp("clr_held", 8'h00, 1'b0, 1'b0);
    cyc(); check(q, tc, rco);
    clr_n = 1'b1;
    push_exp("clr_release", 8'h01, 1'b0, 1'b0);
    cyc(); check(q, tc, rco);

    // up wrap with MAX = 9
    max = 8'd9; sclr_n = 1'b0;
    push_exp("sclr_up", 8'h00, 1'b0, 1'b0);
    cyc(); check(q, tc, rco);
    sclr_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      v = 8'(i % 10);
      push_exp("up_wrap", v, v == 8'd9, v == 8'd9);
      cyc(); check(q, tc, rco);
    end
    for (int i = 1; i <= 9; i++) begin
      v = 8'(i);
      push_exp("up_again", v, v == 8'd9, v == 8'd9);
      cyc(); check(q, tc, rco);
    end
    ent = 1'b0;
    push_exp("ent_drop_comb", 8'd9, 1'b1, 1'b0);
    #1; check(q, tc, rco);
    push_exp("ent_drop_hold", 8'd9, 1'b1, 1'b0);
    cyc(); check(q, tc, rco);

    // down wrap with MAX = 0x0C
    ent = 1'b1; up = 1'b0; max = 8'h0C; load_n = 1'b0; d = 8'h02;
    push_exp("dn_load", 8'h02, 1'b0, 1'b0);
    cyc(); check(q, tc, rco);
    load_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_exp("dn_wrap", dn[i], dn[i] == 8'h00, dn[i] == 8'h00);
      cyc(); check(q, tc, rco);
    end

    // priority: clear beats load, load ignores enables
    load_n = 1'b0; d = 8'h05;
    push_exp("pri_load5", 8'h05, 1'b0, 1'b0);
    cyc(); check(q, tc, rco);
    sclr_n = 1'b0; d = 8'hAA;
    push_exp("pri_clr_load", 8'h00, 1'b1, 1'b1);
    cyc(); check(q, tc, rco);
    sclr_n = 1'b1; enp = 1'b0;
    push_exp("pri_load_noen", 8'hAA, 1'b0, 1'b0);
    cyc(); check(q, tc, rco);

    // out of range with MAX = 0x10
    max = 8'h10; up = 1'b1; d = 8'h80;
    push_exp("oor_up_load", 8'h80, 1'b1, 1'b1);
    cyc(); check(q, tc, rco);
    load_n = 1'b1; enp = 1'b1;
    push_exp("oor_up_wrap", 8'h00, 1'b0, 1'b0);
    cyc(); check(q, tc, rco);
    up = 1'b0; load_n = 1'b0; enp = 1'b0;
    push_exp("oor_dn_load", 8'h80, 1'b0, 1'b0);
    cyc(); check(q, tc, rco);
    load_n = 1'b1; enp = 1'b1;
    push_exp("oor_dn_step", 8'h7F, 1'b0, 1'b0);
    cyc(); check(q, tc, rco);

    // MAX and UP changed just before the edge take effect on that edge
    max = 8'h90; up = 1'b1;
    push_exp("max_up_change", 8'h80, 1'b0, 1'b0);
    cyc(); check(q, tc, rco);

    // MAX = 0 degenerate range
    max = 8'h00; sclr_n = 1'b0;
    push_exp("max0_clr", 8'h00, 1'b1, 1'b1);
    cyc(); check(q, tc, rco);
    sclr_n = 1'b1;
    push_exp("max0_up", 8'h00, 1'b1, 1'b1);
    cyc(); check(q, tc, rco);
    up = 1'b0;
    push_exp("max0_dn", 8'h00, 1'b1, 1'b1);
    cyc(); check(q, tc, rco);

    // two-stage cascade, 256 edges
    c_sclr_n = 1'b0; c_enp = 1'b1;
    push_exp("casc_clr", 8'h00, 1'b0, 1'b0);
    cyc(); check({hi_q, lo_q}, hi_tc, hi_rco);
    c_sclr_n = 1'b1;
    for (int e = 1; e <= 256; e++) begin
      v = 8'(e % 256);
      push_exp("casc", v, v[7:4] == 4'hF, v == 8'hFF);
      cyc(); check({hi_q, lo_q}, hi_tc, hi_rco);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
